wb_test_sequencer: RTL and testbench

//  Parametrised sequencer for top-level bench sub-tests. Holds N sub-test

---
 rtl/wb_test_sequencer_if.sv | 28 ++
 rtl/wb_test_sequencer.sv | 115 +++++++++++
 tb/tb_wb_test_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_test_sequencer_if.sv
// Handshake bundle between the sub-test sequencer (master) and the top bench
// holding the sub-test benches (slave).
interface wb_test_sequencer_if #(
    parameter int NUM_TESTS = 2
);
    localparam int IDX_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;

    logic                 start_i;
    logic [NUM_TESTS-1:0] test_done_i;
    logic [NUM_TESTS-1:0] test_fail_i;
    logic [NUM_TESTS-1:0] test_rst_o;
    logic                 busy_o;
    logic [IDX_W-1:0]     cur_test_o;
    logic [NUM_TESTS-1:0] fail_o;
    logic [NUM_TESTS-1:0] timeout_o;
    logic                 all_done_o;
    logic                 pass_o;

    modport master (
        input  start_i, test_done_i, test_fail_i,
        output test_rst_o, busy_o, cur_test_o, fail_o, timeout_o, all_done_o, pass_o
    );

    modport slave (
        output start_i, test_done_i, test_fail_i,
        input  test_rst_o, busy_o, cur_test_o, fail_o, timeout_o, all_done_o, pass_o
    );
endinterface

// File: rtl/wb_test_sequencer.sv
// Releases N sub-test benches from reset one at a time, records fail/timeout per test.
// Optional WB_TEST_SEQ_STOP_ON_FAIL_EN: a failing or timed-out test ends the sequence.
module wb_test_sequencer #(
    parameter int NUM_TESTS      = 2,
    parameter int SETTLE_CYCLES  = 10,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    wb_test_sequencer_if.master  bus
);
    localparam int IDX_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;
    localparam logic [31:0]      SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0]      TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_TESTS - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_RUN, S_POST, S_FIN} state_t;

    state_t               state, state_nx;
    logic [31:0]          cnt;
    logic [IDX_W-1:0]     cur, cur_nx;
    logic [NUM_TESTS-1:0] fail_q, fail_nx, tmo_q, tmo_nx;
    logic                 done_d, done_d_nx;
    logic                 done_cur, done_edge, settle_end, tmo_hit, last_test;
    logic [NUM_TESTS-1:0] rst_vec;

    assign done_cur   = bus.test_done_i[cur];
    assign done_edge  = done_cur & ~done_d;
    assign settle_end = (cnt == SETTLE_LAST);
    assign tmo_hit    = (cnt == TMO_LAST);

`ifdef WB_TEST_SEQ_STOP_ON_FAIL_EN
    assign last_test = (cur == IDX_LAST) | fail_q[cur] | tmo_q[cur];
`else
    assign last_test = (cur == IDX_LAST);
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state  <= S_IDLE;
            cnt    <= '0;
            cur    <= '0;
            fail_q <= '0;
            tmo_q  <= '0;
            done_d <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= (state_nx != state) ? '0 : cnt + 32'd1;
            cur    <= cur_nx;
            fail_q <= fail_nx;
            tmo_q  <= tmo_nx;
            done_d <= done_d_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cur_nx    = cur;
        fail_nx   = fail_q;
        tmo_nx    = tmo_q;
        done_d_nx = done_d;
        case (state)
            S_IDLE, S_FIN: begin
                if (bus.start_i) begin
                    state_nx = S_PRE;
                    cur_nx   = '0;
                    fail_nx  = '0;
                    tmo_nx   = '0;
                end
            end
            S_PRE: begin
                // A done level already high at release must not look like an edge.
                if (settle_end) begin
                    state_nx  = S_RUN;
                    done_d_nx = done_cur;
                end
            end
            S_RUN: begin
                done_d_nx = done_cur;
                if (done_edge) begin
                    state_nx     = S_POST;
                    fail_nx[cur] = bus.test_fail_i[cur];
                end else if (tmo_hit) begin
                    state_nx    = S_POST;
                    tmo_nx[cur] = 1'b1;
                end
            end
            S_POST: begin
                if (settle_end) begin
                    if (last_test) begin
                        state_nx = S_FIN;
                    end else begin
                        state_nx = S_PRE;
                        cur_nx   = cur + IDX_W'(1);
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Current test stays out of reset through RUN and the POST drain.
    always_comb begin
        rst_vec = '1;
        if (state == S_RUN || state == S_POST) rst_vec[cur] = 1'b0;
    end

    assign bus.test_rst_o = rst_vec;
    assign bus.busy_o     = (state == S_PRE) || (state == S_RUN) || (state == S_POST);
    assign bus.cur_test_o = cur;
    assign bus.fail_o     = fail_q;
    assign bus.timeout_o  = tmo_q;
    assign bus.all_done_o = (state == S_FIN);
    assign bus.pass_o     = (state == S_FIN) & ~|fail_q & ~|tmo_q;
endmodule

// File: tb/tb_wb_test_sequencer.sv
// Bench for wb_test_sequencer: modelled sub-tests, expected releases/results queued at start.
module tb_wb_test_sequencer;
    localparam int SETTLE = 10;
    localparam int TMO    = 80;

    typedef struct {
        int d0; bit f0; bit p0;
        int d1; bit f1;
        logic [1:0] efail; logic [1:0] etmo; bit epass;
    } vec_t;
    typedef struct { int idx; int cyc; } rel_t;
    typedef struct { int fail; int tmo; int pass; int cur; int cyc; } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    wb_test_sequencer_if #(.NUM_TESTS(2)) bus ();

    wb_test_sequencer #(
        .NUM_TESTS(2), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vec_t vecs[8];
    rel_t exp_rel[$];
    res_t exp_res[$];
    int   n_tests = 0, n_fail = 0;
    int   cd[2], rel_cnt[2];
    bit   cf[2], cp[2];
    logic [1:0] prev_rst = 2'b11;
    logic prev_alldone = 1'b0;
    bit   done_seen;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: sub-bench model drives done/fail, then the monitor pops the scoreboard.
    task automatic tick();
        rel_t e;
        res_t r;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (bus.test_rst_o[i]) begin
                rel_cnt[i] = 0;
                bus.test_done_i[i] = cp[i];
                bus.test_fail_i[i] = 1'b0;
            end else begin
                rel_cnt[i]++;
                if (cp[i] && cd[i] != 0 && rel_cnt[i] == 2) bus.test_done_i[i] = 1'b0;
                if (cd[i] != 0 && rel_cnt[i] == cd[i]) begin
                    bus.test_done_i[i] = 1'b1;
                    bus.test_fail_i[i] = cf[i];
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (prev_rst[i] && !bus.test_rst_o[i]) begin
                if (exp_rel.size() == 0) begin
                    chk("unexpected_release", i, -1);
                end else begin
                    e = exp_rel.pop_front();
                    chk("release_idx", i, e.idx);
                    chk("release_cyc", cyc, e.cyc);
                    chk("cur_at_release", int'(bus.cur_test_o), i);
                end
            end
        end
        if (!prev_alldone && bus.all_done_o) begin
            done_seen = 1'b1;
            if (exp_res.size() == 0) begin
                chk("unexpected_all_done", 1, 0);
            end else begin
                r = exp_res.pop_front();
                chk("fin_cyc", cyc, r.cyc);
                chk("fail_o", int'(bus.fail_o), r.fail);
                chk("timeout_o", int'(bus.timeout_o), r.tmo);
                chk("pass_o", int'(bus.pass_o), r.pass);
                chk("cur_at_fin", int'(bus.cur_test_o), r.cur);
                chk("busy_at_fin", int'(bus.busy_o), 0);
            end
        end
        prev_rst     = bus.test_rst_o;
        prev_alldone = bus.all_done_o;
    endtask

    task automatic run_vec(input int v, input int pulse_at);
        vec_t t;
        int   s, r0, r1, f, k;
        bit   stop0;
        t = vecs[v];
        cd[0] = t.d0; cf[0] = t.f0; cp[0] = t.p0;
        cd[1] = t.d1; cf[1] = t.f1; cp[1] = 1'b0;
        tick();
        r0 = (t.d0 != 0 && t.d0 <= TMO) ? t.d0 : TMO;
        r1 = (t.d1 != 0 && t.d1 <= TMO) ? t.d1 : TMO;
        stop0 = 1'b0;
`ifdef WB_TEST_SEQ_STOP_ON_FAIL_EN
        stop0 = t.efail[0] | t.etmo[0];
`endif
        s = cyc + 1;
        exp_rel.push_back('{0, s + SETTLE});
        if (!stop0) begin
            exp_rel.push_back('{1, s + 3*SETTLE + r0});
            f = s + 4*SETTLE + r0 + r1;
        end else begin
            f = s + 2*SETTLE + r0;
        end
        exp_res.push_back('{int'(t.efail), int'(t.etmo), int'(t.epass), stop0 ? 0 : 1, f});
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk("busy_after_start", int'(bus.busy_o), 1);
        chk("all_done_cleared", int'(bus.all_done_o), 0);
        chk("fail_cleared", int'(bus.fail_o), 0);
        chk("timeout_cleared", int'(bus.timeout_o), 0);
        chk("cur_cleared", int'(bus.cur_test_o), 0);
        done_seen = 1'b0;
        k = 0;
        while (!done_seen && k < 2000) begin
            if (pulse_at != 0 && k == pulse_at) bus.start_i = 1'b1;
            tick();
            bus.start_i = 1'b0;
            if (pulse_at != 0 && k == pulse_at) chk("busy_after_pulse", int'(bus.busy_o), 1);
            k++;
        end
        if (!done_seen) chk("fin_reached", 0, 1);
    endtask

    initial begin
        int k;
        //           d0  f0 p0  d1  f1  efail  etmo   pass
        vecs[0] = '{50, 0, 0, 30, 0, 2'b00, 2'b00, 1};  // both pass
        vecs[1] = '{ 0, 0, 0, 30, 0, 2'b00, 2'b01, 0};  // test0 times out
        vecs[2] = '{20, 0, 0, 15, 1, 2'b10, 2'b00, 0};  // test1 fails
        vecs[3] = '{25, 1, 0, 10, 0, 2'b01, 2'b00, 0};  // test0 fails
        vecs[4] = '{40, 0, 1,  5, 0, 2'b00, 2'b00, 1};  // done high at release, drop, re-raise
        vecs[5] = '{80, 0, 0,  1, 0, 2'b00, 2'b00, 1};  // done in the timeout cycle
        vecs[6] = '{ 0, 0, 1, 20, 0, 2'b00, 2'b01, 0};  // done stuck high: no edge
        vecs[7] = '{ 1, 0, 0, 80, 1, 2'b10, 2'b00, 0};  // shortest and longest runs
        cd = '{0, 0}; cf = '{0, 0}; cp = '{0, 0};
        bus.start_i = 1'b0;
        bus.test_done_i = 2'b00;
        bus.test_fail_i = 2'b00;

        repeat (3) tick();
        chk("rst_test_rst", int'(bus.test_rst_o), 3);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_cur", int'(bus.cur_test_o), 0);
        chk("rst_fail", int'(bus.fail_o), 0);
        chk("rst_timeout", int'(bus.timeout_o), 0);
        chk("rst_all_done", int'(bus.all_done_o), 0);
        chk("rst_pass", int'(bus.pass_o), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        run_vec(0, 0);
        run_vec(1, 0);
        run_vec(2, 15);
        for (int v = 3; v < 8; v++) run_vec(v, 0);

        // Reset pulse in the middle of test0's RUN aborts without completion.
        cd = '{60, 0}; cf = '{0, 0}; cp = '{0, 0};
        tick();
        exp_rel.push_back('{0, cyc + 1 + SETTLE});
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        k = 0;
        while (k < SETTLE + 20) begin
            tick();
            k++;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_test_rst", int'(bus.test_rst_o), 3);
        chk("abort_busy", int'(bus.busy_o), 0);
        chk("abort_cur", int'(bus.cur_test_o), 0);
        chk("abort_all_done", int'(bus.all_done_o), 0);
        tick();
        rst_n = 1'b1;
        chk("abort_release_seen", exp_rel.size(), 0);
        repeat (3) tick();
        chk("abort_no_fin", int'(bus.all_done_o), 0);
        run_vec(0, 0);

        chk("rel_queue_empty", exp_rel.size(), 0);
        chk("res_queue_empty", exp_res.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
